// File: rtl/pkt_fwd_pkg.sv
// Shared constants for the store-and-forward packet buffer: read FSM
// encoding and the saturating drop counter limits.
package pkt_fwd_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int              DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;
endpackage

// File: rtl/pkt_fwd_mem.sv
// Frame buffer storage: DEPTH entries of data plus a last-of-frame flag.
// Async read; the last flag has its own set port used at frame commit.
module pkt_fwd_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              last_set,
    input  logic [AW-1:0]     last_addr,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rlast
);
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  last_q;

    always_ff @(posedge clk) begin
        if (we) data_q[waddr] <= wdata;
    end

    // A fresh write always clears the flag; commit sets it on a later cycle.
    always_ff @(posedge clk) begin
        if (we)       last_q[waddr]     <= 1'b0;
        if (last_set) last_q[last_addr] <= 1'b1;
    end

    assign rdata = data_q[raddr];
    assign rlast = last_q[raddr];
endmodule

// File: rtl/pkt_fwd.sv
// Store-and-forward frame buffer: whole frames are committed before being
// replayed on tx with a minimum inter-frame gap; frames that cannot fit are dropped.
module pkt_fwd
    import pkt_fwd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int IFG    = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] rxd,
    input  logic              rx_dv,
    output logic [DATA_W-1:0] txd,
    output logic              tx_en,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              buf_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int GW = $clog2(IFG + 1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [GW-1:0] GAP_END = GW'(IFG - 1);

    logic [PW-1:0] wr_ptr, sop_ptr, commit_ptr, rd_ptr, used, last_ptr;
    logic          dropping, skip, dv_q;
    logic          dv, wr_ok, last_set;
    logic [1:0]    state;
    logic [GW-1:0] gap_cnt;
    logic [DATA_W-1:0] rdata;
    logic          rlast;

    // skip masks the tail of a frame that was already running when reset released
    assign dv       = rx_dv & ~skip;
    assign used     = wr_ptr - rd_ptr;
    assign wr_ok    = dv & ~dropping & (used < DEPTH_P);
    assign last_set = ~dv & dv_q & ~dropping;
    assign last_ptr = wr_ptr - PW'(1);
    assign buf_full = (used == DEPTH_P);

    pkt_fwd_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk       (clk),
        .we        (wr_ok),
        .waddr     (wr_ptr[AW-1:0]),
        .wdata     (rxd),
        .last_set  (last_set),
        .last_addr (last_ptr[AW-1:0]),
        .raddr     (rd_ptr[AW-1:0]),
        .rdata     (rdata),
        .rlast     (rlast)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            sop_ptr    <= '0;
            commit_ptr <= '0;
            dropping   <= 1'b0;
            skip       <= 1'b1;
            dv_q       <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            dv_q <= dv;
            if (!rx_dv) skip <= 1'b0;
            if (dv) begin
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end else if (!dropping) begin
                    // no room: discard everything written for this frame
                    dropping <= 1'b1;
                    wr_ptr   <= sop_ptr;
                end
            end else if (dv_q) begin
                sop_ptr <= wr_ptr;
                if (dropping) begin
                    dropping <= 1'b0;
                    if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 8'd1;
                end else begin
                    commit_ptr <= wr_ptr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            rd_ptr  <= '0;
            txd     <= '0;
            tx_en   <= 1'b0;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    gap_cnt <= '0;
                    if (rd_ptr != commit_ptr) begin
                        txd    <= rdata;
                        tx_en  <= 1'b1;
                        rd_ptr <= rd_ptr + PW'(1);
                        state  <= rlast ? ST_GAP : ST_SEND;
                    end else begin
                        txd   <= '0;
                        tx_en <= 1'b0;
                    end
                end
                ST_SEND: begin
                    gap_cnt <= '0;
                    txd     <= rdata;
                    tx_en   <= 1'b1;
                    rd_ptr  <= rd_ptr + PW'(1);
                    if (rlast) state <= ST_GAP;
                end
                ST_GAP: begin
                    txd   <= '0;
                    tx_en <= 1'b0;
                    if (gap_cnt == GAP_END) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    txd   <= '0;
                    tx_en <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_fwd.sv
// Directed bench for pkt_fwd (DATA_W=8, DEPTH=8, IFG=2): a frame table plus
// hand sequences for back-to-back bursts, mid-run reset and counter saturation.
module tb_pkt_fwd;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int IFG    = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [DATA_W-1:0] rxd;
    logic              rx_dv;
    logic [DATA_W-1:0] txd;
    logic              tx_en;
    logic [7:0]        drop_cnt;
    logic              buf_full;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int         len;
        logic [7:0] base;
        logic       fwd;
        logic       full;
        logic [7:0] drop;
    } vec_t;

    vec_t vecs [6];

    logic       rec = 1'b0;
    int         trace_n = 0;
    logic [8:0] trace [64];

    pkt_fwd #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IFG(IFG)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rxd      (rxd),
        .rx_dv    (rx_dv),
        .txd      (txd),
        .tx_en    (tx_en),
        .drop_cnt (drop_cnt),
        .buf_full (buf_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rec && trace_n < 64) begin
            trace[trace_n] = {tx_en, txd};
            trace_n++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_frame(input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            rxd   = base + 8'(i);
            rx_dv = 1'b1;
        end
        @(posedge clk); #1;
        rx_dv = 1'b0;
        rxd   = '0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int hi;
        logic [7:0] exp_d;
        send_frame(v.len, v.base);
        chk({tag, "_full"}, 32'(buf_full), 32'(v.full));
        @(posedge clk); #1;
        chk({tag, "_commit_edge_en"}, 32'(tx_en), 32'd0);
        if (v.fwd) begin
            for (int i = 0; i < v.len; i++) begin
                @(posedge clk); #1;
                exp_d = v.base + 8'(i);
                chk($sformatf("%s_en%0d", tag, i), 32'(tx_en), 32'd1);
                chk($sformatf("%s_d%0d", tag, i), 32'(txd), 32'(exp_d));
            end
            @(posedge clk); #1;
            chk({tag, "_end_en"}, 32'(tx_en), 32'd0);
            repeat (IFG + 2) @(posedge clk);
            #1;
        end else begin
            hi = 0;
            repeat (v.len + 4) begin
                @(posedge clk); #1;
                if (tx_en) hi++;
            end
            chk({tag, "_no_tx"}, 32'(hi), 32'd0);
        end
        chk({tag, "_drop"}, 32'(drop_cnt), 32'(v.drop));
    endtask

    initial begin
        int first;
        int hi;
        logic [8:0] exp_tr [6];

        vecs[0] = '{len: 3,  base: 8'hA1, fwd: 1'b1, full: 1'b0, drop: 8'd0};
        vecs[1] = '{len: 8,  base: 8'h10, fwd: 1'b1, full: 1'b1, drop: 8'd0};
        vecs[2] = '{len: 9,  base: 8'h20, fwd: 1'b0, full: 1'b0, drop: 8'd1};
        vecs[3] = '{len: 2,  base: 8'hD1, fwd: 1'b1, full: 1'b0, drop: 8'd1};
        vecs[4] = '{len: 1,  base: 8'h55, fwd: 1'b1, full: 1'b0, drop: 8'd1};
        vecs[5] = '{len: 12, base: 8'h60, fwd: 1'b0, full: 1'b0, drop: 8'd2};

        rstn = 1'b0; rx_dv = 1'b0; rxd = '0;
        #12;
        chk("rst_txd", 32'(txd), 32'd0);
        chk("rst_en", 32'(tx_en), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_full", 32'(buf_full), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("v%0d", k));

        // Two frames one rx idle apart: bursts must be IFG tx-idle cycles apart
        trace_n = 0; rec = 1'b1;
        @(posedge clk); #1; rxd = 8'hB1; rx_dv = 1'b1;
        @(posedge clk); #1; rxd = 8'hB2;
        @(posedge clk); #1; rx_dv = 1'b0; rxd = '0;
        @(posedge clk); #1; rxd = 8'hC1; rx_dv = 1'b1;
        @(posedge clk); #1; rx_dv = 1'b0; rxd = '0;
        repeat (12) @(posedge clk);
        #2; rec = 1'b0;
        exp_tr[0] = {1'b1, 8'hB1}; exp_tr[1] = {1'b1, 8'hB2};
        exp_tr[2] = 9'h000;        exp_tr[3] = 9'h000;
        exp_tr[4] = {1'b1, 8'hC1}; exp_tr[5] = 9'h000;
        first = -1;
        for (int i = 0; i < trace_n; i++) if (first < 0 && trace[i][8]) first = i;
        chk("bb_found", 32'(first >= 0 && first + 6 <= trace_n), 32'd1);
        if (first >= 0 && first + 6 <= trace_n)
            for (int i = 0; i < 6; i++)
                chk($sformatf("bb_tr%0d", i), 32'(trace[first+i]), 32'(exp_tr[i]));

        // Reset mid-transmission with rx_dv held high across release
        send_frame(4, 8'h70);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_tx_active", 32'(tx_en), 32'd1);
        #2;
        rstn = 1'b0; rx_dv = 1'b1; rxd = 8'h99;
        #1;
        chk("mrst_txd", 32'(txd), 32'd0);
        chk("mrst_en", 32'(tx_en), 32'd0);
        chk("mrst_drop", 32'(drop_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1; rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1; rx_dv = 1'b0; rxd = '0;
        hi = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (tx_en) hi++;
        end
        chk("mrst_no_tx", 32'(hi), 32'd0);
        chk("mrst_full", 32'(buf_full), 32'd0);
        run_vec('{len: 3, base: 8'hE0, fwd: 1'b1, full: 1'b0, drop: 8'd0}, "post_rst");

        // Saturation of the drop counter
        for (int i = 0; i < 300; i++) begin
            send_frame(9, 8'(i));
            if (i == 253) begin
                @(posedge clk); #1;
                chk("drop_254", 32'(drop_cnt), 32'd254);
            end
        end
        @(posedge clk); #1;
        chk("drop_sat", 32'(drop_cnt), 32'd255);
        chk("sat_en", 32'(tx_en), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
